// File: rtl/butterfly_pipe_if.sv
// Handshake and operand bus for the pipelined radix-2 butterfly.
// The DUT takes the slave view; the producer/consumer side takes master.
interface butterfly_pipe_if #(
  parameter int DATA_W = 32
);
  logic                     recv_val;
  logic                     recv_rdy;
  logic signed [DATA_W-1:0] ar, ac, br, bc, wr, wc;
  logic                     inv;
  logic                     scale;
  logic                     send_val;
  logic                     send_rdy;
  logic signed [DATA_W-1:0] cr, cc, dr, dc;

  modport slave (
    input  recv_val, ar, ac, br, bc, wr, wc, inv, scale, send_rdy,
    output recv_rdy, send_val, cr, cc, dr, dc
  );

  modport master (
    output recv_val, ar, ac, br, bc, wr, wc, inv, scale, send_rdy,
    input  recv_rdy, send_val, cr, cc, dr, dc
  );
endinterface

// File: rtl/butterfly_pipe.sv
// Fully pipelined radix-2 DIT butterfly: c = a + w*b, d = a - w*b, one per cycle,
// with optional conjugated twiddle and 1/2 output scaling per transaction.
module butterfly_pipe #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int MULT   = 1
) (
  input logic             clk,
  input logic             reset,
  butterfly_pipe_if.slave bus
);

  function automatic logic signed [DATA_W-1:0] mul_trunc(
    input logic signed [DATA_W-1:0] x,
    input logic signed [DATA_W-1:0] y
  );
    logic signed [2*DATA_W-1:0] p;
    p = $signed({{DATA_W{x[DATA_W-1]}}, x}) * $signed({{DATA_W{y[DATA_W-1]}}, y});
    return p[DATA_W+FRAC_W-1:FRAC_W];
  endfunction

  function automatic logic signed [DATA_W-1:0] scale_out(
    input logic signed [DATA_W-1:0] x,
    input logic                     s
  );
    return s ? (x >>> 1) : x;
  endfunction

  logic en;
  assign en           = !bus.send_val || bus.send_rdy;
  assign bus.recv_rdy = en;

  logic signed [DATA_W-1:0] ar_s, ac_s, pr_s, pc_s;
  logic                     scale_s;
  logic                     vld_s;

  generate
    if (MULT != 0) begin : g_mult
      logic signed [DATA_W-1:0] ar_p0, ac_p0, br_p0, bc_p0, wr_p0, wc_p0;
      logic                     inv_p0, scale_p0, vld_p0;
      logic signed [DATA_W-1:0] ar_p1, ac_p1;
      logic signed [DATA_W-1:0] prod_rr_p1, prod_cc_p1, prod_rc_p1, prod_cr_p1;
      logic                     scale_p1, vld_p1;
      logic signed [DATA_W-1:0] wc_eff;

      // S1: register operands and mode bits
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld_p0   <= 1'b0;
          ar_p0    <= '0;
          ac_p0    <= '0;
          br_p0    <= '0;
          bc_p0    <= '0;
          wr_p0    <= '0;
          wc_p0    <= '0;
          inv_p0   <= 1'b0;
          scale_p0 <= 1'b0;
        end else if (en) begin
          vld_p0 <= bus.recv_val;
          if (bus.recv_val) begin
            ar_p0    <= bus.ar;
            ac_p0    <= bus.ac;
            br_p0    <= bus.br;
            bc_p0    <= bus.bc;
            wr_p0    <= bus.wr;
            wc_p0    <= bus.wc;
            inv_p0   <= bus.inv;
            scale_p0 <= bus.scale;
          end
        end
      end

      assign wc_eff = inv_p0 ? -wc_p0 : wc_p0;

      // S2: four truncated partial products, each floored to the operand format
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          vld_p1     <= 1'b0;
          ar_p1      <= '0;
          ac_p1      <= '0;
          prod_rr_p1 <= '0;
          prod_cc_p1 <= '0;
          prod_rc_p1 <= '0;
          prod_cr_p1 <= '0;
          scale_p1   <= 1'b0;
        end else if (en) begin
          vld_p1 <= vld_p0;
          if (vld_p0) begin
            ar_p1      <= ar_p0;
            ac_p1      <= ac_p0;
            prod_rr_p1 <= mul_trunc(br_p0, wr_p0);
            prod_cc_p1 <= mul_trunc(bc_p0, wc_eff);
            prod_rc_p1 <= mul_trunc(br_p0, wc_eff);
            prod_cr_p1 <= mul_trunc(bc_p0, wr_p0);
            scale_p1   <= scale_p0;
          end
        end
      end

      assign ar_s    = ar_p1;
      assign ac_s    = ac_p1;
      assign pr_s    = prod_rr_p1 - prod_cc_p1;
      assign pc_s    = prod_rc_p1 + prod_cr_p1;
      assign scale_s = scale_p1;
      assign vld_s   = vld_p1;
    end else begin : g_bypass
      // Twiddle is implicitly 1.0, so b feeds the combine stage directly.
      assign ar_s    = bus.ar;
      assign ac_s    = bus.ac;
      assign pr_s    = bus.br;
      assign pc_s    = bus.bc;
      assign scale_s = bus.scale;
      assign vld_s   = bus.recv_val;
    end
  endgenerate

  logic signed [DATA_W-1:0] cr_p2, cc_p2, dr_p2, dc_p2;
  logic                     vld_p2;

  // S3: add/sub, optional halving, registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p2 <= 1'b0;
      cr_p2  <= '0;
      cc_p2  <= '0;
      dr_p2  <= '0;
      dc_p2  <= '0;
    end else if (en) begin
      vld_p2 <= vld_s;
      if (vld_s) begin
        cr_p2 <= scale_out(ar_s + pr_s, scale_s);
        cc_p2 <= scale_out(ac_s + pc_s, scale_s);
        dr_p2 <= scale_out(ar_s - pr_s, scale_s);
        dc_p2 <= scale_out(ac_s - pc_s, scale_s);
      end
    end
  end

  assign bus.send_val = vld_p2;
  assign bus.cr       = cr_p2;
  assign bus.cc       = cc_p2;
  assign bus.dr       = dr_p2;
  assign bus.dc       = dc_p2;

endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed bench for butterfly_pipe: 3-stage (MULT=1) and 1-stage (MULT=0) variants.
module tb_butterfly_pipe;
  localparam logic [31:0] ONE = 32'h0001_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  butterfly_pipe_if #(.DATA_W(32)) bf1 ();
  butterfly_pipe_if #(.DATA_W(32)) bf0 ();

  butterfly_pipe #(.DATA_W(32), .FRAC_W(16), .MULT(1)) u_mult (
    .clk(clk), .reset(reset), .bus(bf1)
  );
  butterfly_pipe #(.DATA_W(32), .FRAC_W(16), .MULT(0)) u_bypass (
    .clk(clk), .reset(reset), .bus(bf0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic [31:0] a_r, a_c, b_r, b_c, w_r, w_c,
                        input logic iv, sc);
    bf1.ar = a_r; bf1.ac = a_c; bf1.br = b_r; bf1.bc = b_c;
    bf1.wr = w_r; bf1.wc = w_c; bf1.inv = iv; bf1.scale = sc;
    bf1.recv_val = 1'b1;
  endtask

  task automatic drive0(input logic [31:0] a_r, a_c, b_r, b_c, w_r, w_c,
                        input logic iv, sc);
    bf0.ar = a_r; bf0.ac = a_c; bf0.br = b_r; bf0.bc = b_c;
    bf0.wr = w_r; bf0.wc = w_c; bf0.inv = iv; bf0.scale = sc;
    bf0.recv_val = 1'b1;
  endtask

  // One transaction through the 3-stage pipe: accept edge, then two more edges.
  task automatic xact1(input string tag, input logic [31:0] a_r, a_c, b_r, b_c, w_r, w_c,
                       input logic iv, sc, input logic [31:0] ecr, ecc, edr, edc);
    drive1(a_r, a_c, b_r, b_c, w_r, w_c, iv, sc);
    tick;
    bf1.recv_val = 1'b0;
    tick;
    chk({tag, ".lat"}, bf1.send_val, 1'b0);
    tick;
    chk({tag, ".val"}, bf1.send_val, 1'b1);
    chk({tag, ".out"}, {bf1.cr, bf1.cc, bf1.dr, bf1.dc}, {ecr, ecc, edr, edc});
  endtask

  function automatic logic [31:0] tmul(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return 32'(p >>> 16);
  endfunction

  function automatic logic [31:0] half(input logic [31:0] x, input logic sc);
    return sc ? {x[31], x[31:1]} : x;
  endfunction

  function automatic logic [127:0] model(input logic [31:0] a_r, a_c, b_r, b_c, w_r, w_c,
                                         input logic iv, sc);
    logic [31:0] wcp, pr, pc;
    wcp = iv ? (32'd0 - w_c) : w_c;
    pr  = tmul(b_r, w_r) - tmul(b_c, wcp);
    pc  = tmul(b_r, wcp) + tmul(b_c, w_r);
    return {half(a_r + pr, sc), half(a_c + pc, sc), half(a_r - pr, sc), half(a_c - pc, sc)};
  endfunction

  logic [31:0]  rv [16][6];
  logic         rinv [16];
  logic         rscale [16];
  logic [127:0] expq [$];
  logic [127:0] held;
  logic         hold;
  logic         acc;
  int           sent;
  int           got;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    drive1(0, 0, 0, 0, 0, 0, 0, 0);
    drive0(0, 0, 0, 0, 0, 0, 0, 0);
    bf1.recv_val = 1'b0; bf0.recv_val = 1'b0;
    bf1.send_rdy = 1'b1; bf0.send_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.val1", bf1.send_val, 1'b0);
    chk("rst.out1", {bf1.cr, bf1.cc, bf1.dr, bf1.dc}, 128'd0);
    chk("rst.rdy1", bf1.recv_rdy, 1'b1);
    chk("rst.val0", bf0.send_val, 1'b0);
    chk("rst.rdy0", bf0.recv_rdy, 1'b1);
    reset = 1'b0;
    tick;

    xact1("unit", ONE, 0, ONE, 0, ONE, 0, 1'b0, 1'b0, 32'h0002_0000, 0, 0, 0);
    xact1("jw", 0, 0, ONE, 0, 0, ONE, 1'b0, 1'b0, 0, ONE, 0, 32'hFFFF_0000);
    xact1("jw_inv", 0, 0, ONE, 0, 0, ONE, 1'b1, 1'b0, 0, 32'hFFFF_0000, 0, ONE);
    xact1("scale", ONE, 0, ONE, 0, ONE, 0, 1'b0, 1'b1, ONE, 0, 0, 0);
    xact1("floor", 32'hFFFF_FFFD, 0, 0, 0, ONE, 0, 1'b0, 1'b1,
          32'hFFFF_FFFE, 0, 32'hFFFF_FFFE, 0);
    xact1("wrap", 32'h7FFF_FFFF, 0, 32'd1, 0, ONE, 0, 1'b0, 1'b0,
          32'h8000_0000, 0, 32'h7FFF_FFFE, 0);
    xact1("trunc", 0, 0, 32'hFFFF_FFFF, 0, 32'h0000_8000, 0, 1'b0, 1'b0,
          32'hFFFF_FFFF, 0, 32'd1, 0);
    repeat (3) tick;
    chk("drain", bf1.send_val, 1'b0);

    // Random back-to-back traffic with random back-pressure
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 6; j++) rv[i][j] = $urandom;
      rinv[i]   = 1'($urandom_range(0, 1));
      rscale[i] = 1'($urandom_range(0, 1));
    end
    sent = 0; got = 0; hold = 1'b0;
    for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
      bf1.send_rdy = 1'($urandom_range(0, 1));
      if (sent < 16)
        drive1(rv[sent][0], rv[sent][1], rv[sent][2], rv[sent][3], rv[sent][4], rv[sent][5],
               rinv[sent], rscale[sent]);
      else
        bf1.recv_val = 1'b0;
      #1;
      if (hold) begin
        chk("stall.val", bf1.send_val, 1'b1);
        chk("stall.hold", {bf1.cr, bf1.cc, bf1.dr, bf1.dc}, held);
        hold = 1'b0;
      end
      chk("rand.rdy", bf1.recv_rdy, !(bf1.send_val && !bf1.send_rdy));
      if (bf1.send_val && bf1.send_rdy) begin
        if (expq.size() == 0) begin
          chk("rand.spurious", bf1.send_val, 1'b0);
        end else begin
          chk("rand.out", {bf1.cr, bf1.cc, bf1.dr, bf1.dc}, expq.pop_front());
          got++;
        end
      end
      if (bf1.send_val && !bf1.send_rdy) begin
        hold = 1'b1;
        held = {bf1.cr, bf1.cc, bf1.dr, bf1.dc};
      end
      acc = bf1.recv_val && bf1.recv_rdy;
      if (acc) begin
        expq.push_back(model(rv[sent][0], rv[sent][1], rv[sent][2], rv[sent][3],
                             rv[sent][4], rv[sent][5], rinv[sent], rscale[sent]));
        sent++;
      end
      @(posedge clk);
      #1;
    end
    bf1.recv_val = 1'b0;
    bf1.send_rdy = 1'b1;
    chk("rand.count", got, 16);
    repeat (3) tick;

    // Asynchronous reset with three transactions in flight
    drive1(ONE, 0, ONE, 0, ONE, 0, 1'b0, 1'b0);
    tick;
    drive1(32'd1, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    tick;
    drive1(32'd2, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    tick;
    bf1.recv_val = 1'b0;
    chk("inflight.val", bf1.send_val, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst.val", bf1.send_val, 1'b0);
    chk("arst.out", {bf1.cr, bf1.cc, bf1.dr, bf1.dc}, 128'd0);
    chk("arst.rdy", bf1.recv_rdy, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    drive1(32'd5, 32'd7, ONE, 0, ONE, 0, 1'b0, 1'b0);
    tick;
    bf1.recv_val = 1'b0;
    chk("post.e0", bf1.send_val, 1'b0);
    tick;
    chk("post.e1", bf1.send_val, 1'b0);
    tick;
    chk("post.val", bf1.send_val, 1'b1);
    chk("post.out", {bf1.cr, bf1.cc, bf1.dr, bf1.dc},
        {32'h0001_0005, 32'd7, 32'hFFFF_0005, 32'd7});

    // Single-stage variant: w and inv ignored
    chk("b0.idle", bf0.send_val, 1'b0);
    drive0(ONE, 32'd2, 32'd3, 32'd4, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 1'b0);
    tick;
    bf0.recv_val = 1'b0;
    chk("b0.val", bf0.send_val, 1'b1);
    chk("b0.out", {bf0.cr, bf0.cc, bf0.dr, bf0.dc},
        {32'h0001_0003, 32'd6, 32'h0000_FFFD, 32'hFFFF_FFFE});
    drive0(32'd5, 0, 32'd2, 0, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b1);
    tick;
    bf0.recv_val = 1'b0;
    chk("b0.scale", {bf0.cr, bf0.cc, bf0.dr, bf0.dc}, {32'd3, 32'd0, 32'd1, 32'd0});
    bf0.send_rdy = 1'b0;
    drive0(32'd100, 32'd100, 32'd1, 32'd1, 0, 0, 1'b0, 1'b0);
    #1;
    chk("b0.stall.rdy", bf0.recv_rdy, 1'b0);
    tick;
    chk("b0.stall.val", bf0.send_val, 1'b1);
    chk("b0.stall.hold", {bf0.cr, bf0.cc, bf0.dr, bf0.dc}, {32'd3, 32'd0, 32'd1, 32'd0});
    bf0.recv_val = 1'b0;
    bf0.send_rdy = 1'b1;
    tick;
    chk("b0.bubble", bf0.send_val, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/butterfly_pipe.md
# butterfly_pipe

Fully pipelined radix-2 decimation-in-time butterfly for the FFT datapath, with a valid/ready handshake and back-pressure stall. It computes c = a + w·b and d = a − w·b on signed fixed-point complex operands, sustaining one transaction per cycle. Per-transaction mode bits select inverse transform (conjugated twiddle) and ½ output scaling for overflow control in multi-stage FFTs. This is the throughput successor to the iterative-multiplier butterfly: same arithmetic and handshake semantics, no multi-cycle busy period.

## Interface
- n, 32: total word width (bits) of every real/imag operand.
- d, 16: fractional bits (Q(n−d).d two's complement; 1.0 = 1<<d).
- mult, 1: 1 = twiddle multiply present (3-stage pipe); 0 = w ignored, treated as 1.0 (1-stage pipe).

- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- recv_val  in  1  input transaction valid.
- recv_rdy  out  1  block can accept this cycle.
- ar, ac, br, bc, wr, wc  in  n each  real/imag of a, b, twiddle w.
- inv  in  1  1 = use conj(w) (wc negated); sampled with transaction.
- scale  in  1  1 = outputs arithmetic-shifted right by 1; sampled with transaction.
- send_val  out  1  output transaction valid.
- send_rdy  in  1  downstream accepts this cycle.
- cr, cc, dr, dc  out  n each  real/imag of c and d.

## Operation
- Products (mult=1): pr = br·wr' − bc·wc', pc = br·wc' + bc·wr', with wr' = wr, wc' = inv ? −wc : wc (negation mod 2^n). Each 2n-bit signed product truncated to bits [n+d−1:d] (floor toward −∞) before add/sub; wraps mod 2^n, no saturation.
- mult=0: pr = br, pc = bc; wr, wc, inv ignored.
- c = a + p, d = a − p, each component mod 2^n. scale=1: result >>> 1 (arithmetic, floor) applied to the n-bit wrapped sum.
- Pipeline (mult=1): S1 registers operands + mode bits; S2 registers the four n-bit truncated products, a, and mode; S3 registers cr/cc/dr/dc (combine, add/sub, scale). mult=0: single output stage S3.
- Each stage carries a valid bit. Global advance en = !send_val || send_rdy. When en=0 every stage holds (data and valid). recv_rdy = en.
- Accept: recv_val && recv_rdy at a rising edge. Bubbles propagate as valid=0 and do not block advance.
- Inputs not accepted (recv_val=0 or recv_rdy=0) do not alter state.

## Timing
- Reset (async assert, sync-safe deassert): all valid bits 0, all data registers 0 → send_val=0, cr=cc=dr=dc=0, recv_rdy=1 (combinational from en).
- Latency: transaction accepted at edge E0 appears with send_val=1 after edge E0+2 (mult=1) or E0 (mult=0), given no stall.
- Throughput: 1 per cycle with send_rdy held 1; order preserved, no drops, no duplicates.
- Stall: send_val=1 && send_rdy=0 → recv_rdy=0 same cycle; outputs held stable until the cycle send_rdy=1.
- Simultaneous accept and send in one cycle is legal and required at full rate.
- Reset mid-stream: all in-flight transactions discarded; first post-reset output is the first transaction accepted after reset.
- Outputs are registered; recv_rdy is the only combinational output (depends on send_val, send_rdy).

## Test plan
- n=32,d=16,mult=1: a=(1.0,0), b=(1.0,0), w=(1.0,0) i.e. 0x00010000 → after 3 edges c=(0x00020000,0), d=(0,0).
- w=(0,1.0), b=(1.0,0), a=0, inv=0 → c=(0,0x00010000), d=(0,0xFFFF0000); same with inv=1 → c=(0,0xFFFF0000), d=(0,0x00010000).
- scale=1, a=(0x00010000,0), b=w=(1.0,0) → c=(0x00010000,0), d=0; a=(−3 LSB), p=0 → c=−2 LSB (floor).
- Back-to-back 16 random transactions, send_rdy random 50% → outputs match golden model in order, held stable while send_rdy=0, recv_rdy low exactly when send_val&&!send_rdy.
- Overflow: a=0x7FFFFFFF, p=1 LSB → cr=0x80000000 (wrap); truncation of −0.5 LSB product → −1 LSB.
- Reset asserted asynchronously with 3 transactions in flight → send_val and outputs 0 immediately; mult=0 variant: output after one edge, w ignored.
